seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Downstream display stage for the stopwatch counter. Consumes the four BCD
//  digits (min_l, min_r, sec_l, sec_r) and time-multiplexes them onto a 4-digit
//  common-anode 7-segment display. Drives the dp as the min/sec separator.
//  Optionally blinks the digit under adjustment.
// PARAMETERS
//  REFRESH_DIV  100000    clk cycles per digit slot (1 kHz step @100 MHz), >=1
//  BLINK_DIV    25000000  clk cycles per blink phase toggle (2 Hz blink @100 MHz), >=1
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst       in   1  synchronous, active-high reset
//  min_l     in   5  minutes tens digit (valid 0-9)
//  min_r     in   5  minutes ones digit (valid 0-9)
//  sec_l     in   5  seconds tens digit (valid 0-5)
//  sec_r     in   5  seconds ones digit (valid 0-9)
//  adj_mode  in   1  1 = adjust mode active
//  adj_sel   in   3  digit under adjust: 0=min_l 1=min_r 2=sec_l 3=sec_r, 4-7 none
//  seg       out  7  {g,f,e,d,c,b,a}, active-low, registered
//  an        out  4  digit anodes, active-low, one-hot-low, an[0]=sec_r .. an[3]=min_l
//  dp        out  1  decimal point, active-low, registered
// BEHAVIOUR
//  - Reset (rst=1 at posedge): an=4'b1111, seg=7'b1111111, dp=1, scan idx=0,
//    refresh cnt=0, blink cnt=0, blink phase=on. Reset wins over every other event.
//  - Refresh cnt counts 0..REFRESH_DIV-1 and wraps; tick = (cnt==REFRESH_DIV-1).
//  - On tick: idx <= idx+1 mod 4 (0->1->2->3->0). In the same edge, an/seg/dp are
//    loaded for the NEW idx. Latency: outputs change 1 clk after the tick cycle.
//  - First lit digit: idx 1 (sec_l) REFRESH_DIV cycles after reset release;
//    an stays 4'b1111 until then.
//  - idx->digit: 0=sec_r 1=sec_l 2=min_r 3=min_l; an = ~(4'b0001 << idx).
//  - Digit is sampled at the tick edge only; input changes mid-slot are not
//    shown until that position is next scanned.
//  - Decode: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//    6=0000010 7=1111000 8=0000000 9=0010000; values 10-31 -> dash 0111111.
//  - dp=0 only while idx==2 (separator after minutes), else 1.
//  - REFRESH_DIV=1: tick every cycle, idx advances every clk.
//  - Counter widths: $clog2 of the divisor, min 1 bit; no overflow beyond wrap.
// CONFIGURATION
//  SEG_BLINK_EN defined:
//   - Blink cnt counts 0..BLINK_DIV-1; on wrap, phase toggles.
//   - Phase = off, adj_mode=1, and adj_sel maps to current idx
//     (0->3, 1->2, 2->1, 3->0): seg=1111111 and dp=1 for that slot.
//     an still asserts.
//   - adj_sel 4-7 or adj_mode=0: no blanking. Blink cnt is free-running and is
//     not cleared by adj_mode edges.
//  SEG_BLINK_EN undefined:
//   - No blink counter.
//   - adj_mode/adj_sel are ignored (ports kept).
//   - Output identical to blink-enabled build with phase=on.
// TESTING
//  - Reset: rst high 3 clk -> an=1111, seg=1111111, dp=1. Release, REFRESH_DIV=4
//    -> an=1101 at cycle 4 after release, then 1011, 0111, 1110, each 4 clk.
//  - Decode: digits 1,2,3,4 (min_l..sec_r), REFRESH_DIV=2 -> an=1110 seg=0011001.
//    Then an=1101 seg=0110000, an=1011 seg=0100100 dp=0, an=0111 seg=1111001.
//  - Invalid: sec_r=5'd12 -> seg=0111111 in slot an=1110. sec_r=5'd31 -> same dash.
//  - Mid-slot change: sec_l 3->4 one clk after its slot loads -> seg keeps 0110000
//    until next sec_l slot, then 0011001.
//  - Blink (SEG_BLINK_EN, BLINK_DIV=8): adj_mode=1, adj_sel=1 -> min_r slot blank
//    (seg=1111111, dp=1) in off phase, shown in on phase. adj_sel=5 -> never blank.
//    Without macro -> never blank.
//  - Reset mid-operation: rst asserted during idx=2 -> next clk an=1111, dp=1.
//    Scan restarts per first scenario.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes four BCD stopwatch digits onto a 4-digit
// common-anode 7-segment display, with dp used as the min/sec separator.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous, active-high reset
//   min_l     minutes tens digit      min_r  minutes ones digit
//   sec_l     seconds tens digit      sec_r  seconds ones digit
//   adj_mode  1 = adjust mode active
//   adj_sel   digit under adjust: 0=min_l 1=min_r 2=sec_l 3=sec_r, 4-7 none
//   seg       {g,f,e,d,c,b,a}, active-low, registered
//   an        digit anodes, active-low one-hot, an[0]=sec_r .. an[3]=min_l
//   dp        decimal point, active-low, registered
//
// Build option: define SEG_BLINK_EN to blank the digit under adjustment during
// the off phase of a BLINK_DIV-cycle blink toggle. Without it adj_mode/adj_sel
// are ignored and the display behaves as if the blink phase were always on.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] min_l,
    input  logic [4:0] min_r,
    input  logic [4:0] sec_l,
    input  logic [4:0] sec_r,
    input  logic       adj_mode,
    input  logic [2:0] adj_sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic             tick_c;
    logic             blank_c;
    logic [4:0]       digit_c;

    // BCD to active-low segments; anything outside 0-9 shows a dash
    function automatic logic [6:0] decode(input logic [4:0] d);
        logic [6:0] s;
        case (d)
            5'd0:    s = 7'b1000000;
            5'd1:    s = 7'b1111001;
            5'd2:    s = 7'b0100100;
            5'd3:    s = 7'b0110000;
            5'd4:    s = 7'b0011001;
            5'd5:    s = 7'b0010010;
            5'd6:    s = 7'b0000010;
            5'd7:    s = 7'b1111000;
            5'd8:    s = 7'b0000000;
            5'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Refresh divider and scan index
    always_comb begin
        ref_cnt_d = ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        tick_c    = (ref_cnt_q == REF_MAX);
        if (tick_c) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_on_q, phase_on_d;

    // Free-running blink divider; phase flips on each wrap
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
        phase_on_d  = phase_on_q;
        if (blink_cnt_q == BLK_MAX) begin
            blink_cnt_d = '0;
            phase_on_d  = ~phase_on_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
        end
    end

    // adj_sel numbering runs opposite to scan index: idx = 3 - adj_sel = ~adj_sel[1:0]
    assign blank_c = ~phase_on_q & adj_mode & ~adj_sel[2] & (idx_d == ~adj_sel[1:0]);
`else
    logic unused_adj;
    assign unused_adj = &{1'b0, adj_mode, adj_sel};
    assign blank_c    = 1'b0;
`endif

    // Digit selected by the index being loaded
    always_comb begin
        digit_c = sec_r;
        case (idx_d)
            2'd0: digit_c = sec_r;
            2'd1: digit_c = sec_l;
            2'd2: digit_c = min_r;
            2'd3: digit_c = min_l;
            default: digit_c = sec_r;
        endcase
    end

    // Output registers load only at the tick edge, for the new index
    always_comb begin
        seg_d = seg_q;
        an_d  = an_q;
        dp_d  = dp_q;
        if (tick_c) begin
            an_d = ~(4'b0001 << idx_d);
            if (blank_c) begin
                seg_d = SEG_OFF;
                dp_d  = 1'b1;
            end else begin
                seg_d = decode(digit_c);
                dp_d  = (idx_d != 2'd2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
            idx_q     <= 2'd0;
            seg_q     <= SEG_OFF;
            an_q      <= 4'b1111;
            dp_q      <= 1'b1;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver using three instances sharing inputs:
// d4 (REFRESH_DIV=4), d2 (REFRESH_DIV=2, BLINK_DIV=8), d1 (REFRESH_DIV=1).
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] min_l, min_r, sec_l, sec_r;
    logic       adj_mode;
    logic [2:0] adj_sel;

    logic [6:0] seg4, seg2, seg1;
    logic [3:0] an4, an2, an1;
    logic       dp4, dp2, dp1;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S_OFF  = 7'b1111111;
    localparam logic [6:0] S_DASH = 7'b0111111;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) u_d4 (
        .clk(clk), .rst(rst), .min_l(min_l), .min_r(min_r), .sec_l(sec_l),
        .sec_r(sec_r), .adj_mode(adj_mode), .adj_sel(adj_sel),
        .seg(seg4), .an(an4), .dp(dp4));

    seg_scan_driver #(.REFRESH_DIV(2), .BLINK_DIV(8)) u_d2 (
        .clk(clk), .rst(rst), .min_l(min_l), .min_r(min_r), .sec_l(sec_l),
        .sec_r(sec_r), .adj_mode(adj_mode), .adj_sel(adj_sel),
        .seg(seg2), .an(an2), .dp(dp2));

    seg_scan_driver #(.REFRESH_DIV(1), .BLINK_DIV(1)) u_d1 (
        .clk(clk), .rst(rst), .min_l(min_l), .min_r(min_r), .sec_l(sec_l),
        .sec_r(sec_r), .adj_mode(adj_mode), .adj_sel(adj_sel),
        .seg(seg1), .an(an1), .dp(dp1));

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] a, input logic [6:0] s,
                           input logic d, input logic [3:0] ea, input logic [6:0] es,
                           input logic ed);
        chk({tag, ".an"}, {3'b000, a}, {3'b000, ea});
        chk({tag, ".seg"}, s, es);
        chk({tag, ".dp"}, {6'b0, d}, {6'b0, ed});
    endtask

    initial begin
        rst = 1'b1; adj_mode = 1'b0; adj_sel = 3'd0;
        min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;

        // reset held 3 clocks
        step(3);
        chk_out("rst_d4", an4, seg4, dp4, 4'b1111, S_OFF, 1'b1);
        chk_out("rst_d1", an1, seg1, dp1, 4'b1111, S_OFF, 1'b1);
        rst = 1'b0;

        // n = posedges since release
        step(1); // n=1
        chk_out("d1_n1", an1, seg1, dp1, 4'b1101, S3, 1'b1);
        chk("d4_n1.an", {3'b0, an4}, 7'b0001111);
        step(1); // n=2
        chk_out("d1_n2", an1, seg1, dp1, 4'b1011, S2, 1'b0);
        chk_out("d2_n2", an2, seg2, dp2, 4'b1101, S3, 1'b1);
        step(1); // n=3
        chk_out("d1_n3", an1, seg1, dp1, 4'b0111, S1, 1'b1);
        chk_out("d4_n3", an4, seg4, dp4, 4'b1111, S_OFF, 1'b1);
        step(1); // n=4
        chk_out("d1_n4", an1, seg1, dp1, 4'b1110, S4, 1'b1);
        chk_out("d2_n4", an2, seg2, dp2, 4'b1011, S2, 1'b0);
        chk_out("d4_n4", an4, seg4, dp4, 4'b1101, S3, 1'b1);
        step(2); // n=6
        chk_out("d2_n6", an2, seg2, dp2, 4'b0111, S1, 1'b1);
        step(2); // n=8
        chk_out("d2_n8", an2, seg2, dp2, 4'b1110, S4, 1'b1);
        chk_out("d4_n8", an4, seg4, dp4, 4'b1011, S2, 1'b0);
        step(4); // n=12
        chk_out("d4_n12", an4, seg4, dp4, 4'b0111, S1, 1'b1);
        step(4); // n=16
        chk_out("d4_n16", an4, seg4, dp4, 4'b1110, S4, 1'b1);

        // invalid digits produce a dash
        sec_r = 5'd12;
        step(16); // n=32
        chk_out("inv12", an4, seg4, dp4, 4'b1110, S_DASH, 1'b1);
        sec_r = 5'd7;
        step(16); // n=48
        chk_out("dig7", an4, seg4, dp4, 4'b1110, S7, 1'b1);
        sec_r = 5'd31;
        step(16); // n=64
        chk_out("inv31", an4, seg4, dp4, 4'b1110, S_DASH, 1'b1);
        sec_r = 5'd4;

        // mid-slot change is held until the slot comes round again
        step(4); // n=68 sec_l slot loaded
        chk_out("mid_load", an4, seg4, dp4, 4'b1101, S3, 1'b1);
        step(1);
        sec_l = 5'd4;
        step(2); // n=71
        chk_out("mid_hold", an4, seg4, dp4, 4'b1101, S3, 1'b1);
        step(1); // n=72
        chk_out("mid_next", an4, seg4, dp4, 4'b1011, S2, 1'b0);
        step(12); // n=84
        chk_out("mid_new", an4, seg4, dp4, 4'b1101, S4, 1'b1);

        // reset during the idx=2 slot
        step(4); // n=88
        chk_out("pre_rst", an4, seg4, dp4, 4'b1011, S2, 1'b0);
        step(1);
        rst = 1'b1;
        step(1);
        chk_out("mid_rst", an4, seg4, dp4, 4'b1111, S_OFF, 1'b1);
        rst = 1'b0;
        step(3);
        chk("rst_restart_wait.an", {3'b0, an4}, 7'b0001111);
        step(1);
        chk_out("rst_restart", an4, seg4, dp4, 4'b1101, S4, 1'b1);

        // blink run on d2: adjust min_r (adj_sel=1, scan idx 2)
        rst = 1'b1;
        sec_l = 5'd3;
        adj_mode = 1'b1;
        adj_sel = 3'd1;
        step(3);
        rst = 1'b0;
        step(4); // n=4, phase on
        chk_out("blk_on1", an2, seg2, dp2, 4'b1011, S2, 1'b0);
        step(8); // n=12, phase off
`ifdef SEG_BLINK_EN
        chk_out("blk_off", an2, seg2, dp2, 4'b1011, S_OFF, 1'b1);
`else
        chk_out("blk_off", an2, seg2, dp2, 4'b1011, S2, 1'b0);
`endif
        step(8); // n=20, phase on
        chk_out("blk_on2", an2, seg2, dp2, 4'b1011, S2, 1'b0);
        adj_sel = 3'd5;
        step(8); // n=28, phase off but no digit selected
        chk_out("blk_none", an2, seg2, dp2, 4'b1011, S2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
